fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage RISC-V core. Sits directly upstream of decode and feeds the IF/ID register contents (instruction + PC) to the control/decode block.
- Drives the instruction-memory address; imem has a fixed 1-cycle synchronous read latency.
- Handles hazard stalls without losing or duplicating instructions, using a one-entry hold buffer.
- Handles redirects (taken branch, jal/jalr) by flushing in-flight fetches.

Parameters:
- RESET_PC, 32'h0100_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble injected into ID (addi x0,x0,0).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset: sampled at rising edge of clock, asserted when 0.
- stall  in  1  hazard unit: hold ID contents and PC.
- flush  in  1  redirect request from decode/execute (branch taken or pc_jump).
- redirect_pc  in  32  target address, valid when flush=1.
- imem_addr  out  32  word address presented to imem this cycle.
- imem_data  in  32  imem read data for the imem_addr of the previous cycle.
- id_inst  out  32  registered instruction to decode.
- id_pc  out  32  registered PC of id_inst.
- id_valid  out  1  id_inst is a real fetched instruction (0 = bubble).

Behaviour:
- Internal registers: pc_req (drives imem_addr), pc_resp (address whose data arrives this cycle), resp_valid, hold_valid/hold_inst/hold_pc, state.
- FSM states: S_BOOT, S_RUN, S_HOLD.
  - S_BOOT = first cycle after reset; no response is outstanding.
  - S_RUN = normal streaming.
  - S_HOLD = stalled with the hold buffer occupied.
- Reset (reset=0 at edge):
  - pc_req=RESET_PC, pc_resp=0, resp_valid=0, hold_valid=0, state=S_BOOT.
  - id_inst=NOP_INST, id_pc=0, id_valid=0.
  - Reset mid-stall or mid-redirect discards everything.
- Candidate instruction each cycle:
  - If hold_valid: the candidate is (hold_inst, hold_pc).
  - Otherwise, if resp_valid: the candidate is (imem_data, pc_resp).
  - Otherwise there is no candidate.
- Priority: reset > flush > stall > advance.
- Flush (overrides stall):
  - pc_req = {redirect_pc[31:2], 2'b00}; the low bits are forced to 0.
  - resp_valid=0, so the in-flight response is dropped next cycle.
  - hold_valid=0.
  - id_inst=NOP_INST, id_valid=0, id_pc unchanged.
  - state goes to S_RUN.
  - Redirect penalty: target instruction reaches ID exactly 2 edges after the flush edge.
- Stall (no flush):
  - id_* hold their values; pc_req holds.
  - If a candidate exists from imem and hold_valid=0, capture it into the hold buffer (hold_valid=1, state goes to S_HOLD).
  - resp_valid=0 for as long as stall is high. Re-reads of the held pc_req are ignored, so no duplicates.
- Advance (no flush, no stall):
  - id_inst/id_pc take the candidate and id_valid=1; with no candidate, id_inst=NOP_INST and id_valid=0.
  - pc_resp=pc_req, resp_valid=1, pc_req=pc_req+4, hold_valid=0, state goes to S_RUN.
- Release after stall: the held instruction enters ID on the first advance edge. The instruction at the held pc_req arrives the following cycle, giving a gap-free stream.
- PC increment wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- imem_addr is purely the pc_req register: no combinational path from stall/flush to imem_addr.
- Steady-state throughput: 1 instr/cycle. Reset-to-first-valid-ID: 2 edges after reset deasserts.
- flush and stall both high: flush wins. The hold buffer is discarded.

Decomposition:
- Shared package (pipeline pkg): RESET_PC, NOP_INST, fetch FSM state encoding (2-bit enum), IF/ID bundle typedef {inst, pc, valid}.
- One natural sub-module: fetch_skid, the one-entry hold buffer (capture/consume/clear, valid flag).
- PC logic and FSM stay in fetch_stage.

Test Plan:
- Reset release:
  - Stimulus: reset low 3 cycles, then high; imem returns addr-derived data.
  - Response: imem_addr=0x0100_0000, then 0x0100_0004; id_valid=0 for the first edge, then id_pc=0x0100_0000 with id_inst=mem[0x0100_0000]; then consecutive PCs +4 each cycle.
- Stall 3 cycles mid-stream:
  - Stimulus: id_pc=0x0100_0008 at stall assertion.
  - Response: id_pc/id_inst frozen 3 cycles; after release id_pc=0x0100_000C, 0x0100_0010, …; no skipped or duplicated PC.
- Flush:
  - Stimulus: flush with redirect_pc=0x0100_0040.
  - Response: next edge id_valid=0, id_inst=0x0000_0013; imem_addr=0x0100_0040; id_pc=0x0100_0040 valid two edges after the flush.
- Flush+stall same cycle while hold buffer full:
  - Stimulus: redirect_pc=0x0100_0080.
  - Response: hold discarded; first valid id_pc=0x0100_0080; the held instruction never appears.
- Misaligned redirect and wrap:
  - Stimulus: redirect_pc=0x0100_0042.
  - Response: imem_addr=0x0100_0040.
  - Stimulus: redirect_pc=0xFFFF_FFFC.
  - Response: imem_addr sequence 0xFFFF_FFFC, 0x0000_0000.
- Reset during stall:
  - Stimulus: reset=0 while in S_HOLD.
  - Response: id_valid=0, id_inst=NOP_INST; imem_addr=RESET_PC next edge; held data never delivered.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Purpose: shared types and constants for the instruction-fetch stage and its hold buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0100_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,  // first cycle after reset, nothing in flight
    S_RUN  = 2'd1,  // streaming one instruction per cycle
    S_HOLD = 2'd2   // stalled with the hold buffer occupied
  } fetch_state_e;

  // IF/ID register contents handed to decode.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Purpose: one-entry hold buffer that parks an imem response arriving while decode is stalled.
// Latency: captured entry is visible the cycle after capture.
// Backpressure: never refuses a capture; the owner only captures when empty.
// Ports: clock/reset (sync, active-low); capture + capture_inst/capture_pc load the entry;
//        clear empties it (wins over capture); hold_valid/hold_inst/hold_pc expose the entry.
module fetch_skid (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] capture_inst,
  input  logic [31:0] capture_pc,
  input  logic        clear,
  output logic        hold_valid,
  output logic [31:0] hold_inst,
  output logic [31:0] hold_pc
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_inst  <= 32'd0;
      hold_pc    <= 32'd0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      hold_inst  <= capture_inst;
      hold_pc    <= capture_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: RISC-V instruction fetch; drives imem (1-cycle sync read) and the IF/ID register.
// Latency: 2 edges from reset release or redirect to first valid instruction in ID; 1 instr/cycle after.
// Backpressure: stall freezes ID and PC; a response already in flight is parked in the hold buffer.
// Ports: clock, reset (sync, active-low); stall/flush/redirect_pc from hazard and branch logic;
//        imem_addr/imem_data to instruction memory; id_inst/id_pc/id_valid to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid
);

  fetch_state_e state_q, state_n;
  logic [31:0]  pc_req_q, pc_req_n;
  logic [31:0]  pc_resp_q, pc_resp_n;
  logic         resp_valid_q, resp_valid_n;
  if_id_t       if_id_q, if_id_n;

  logic         hold_valid;
  logic [31:0]  hold_inst;
  logic [31:0]  hold_pc;
  logic         hold_capture;
  logic         hold_clear;

  logic         cand_valid;
  logic [31:0]  cand_inst;
  logic [31:0]  cand_pc;

  fetch_skid u_skid (
    .clock        (clock),
    .reset        (reset),
    .capture      (hold_capture),
    .capture_inst (imem_data),
    .capture_pc   (pc_resp_q),
    .clear        (hold_clear),
    .hold_valid   (hold_valid),
    .hold_inst    (hold_inst),
    .hold_pc      (hold_pc)
  );

  // A parked instruction is older than anything on the imem bus, so it goes first.
  assign cand_valid = hold_valid | resp_valid_q;
  assign cand_inst  = hold_valid ? hold_inst : imem_data;
  assign cand_pc    = hold_valid ? hold_pc   : pc_resp_q;

  always_comb begin
    state_n      = state_q;
    pc_req_n     = pc_req_q;
    pc_resp_n    = pc_resp_q;
    resp_valid_n = resp_valid_q;
    if_id_n      = if_id_q;
    hold_capture = 1'b0;
    hold_clear   = 1'b0;

    if (flush) begin
      // Drop the in-flight response and anything parked; the target is fetched next.
      pc_req_n      = word_align(redirect_pc);
      resp_valid_n  = 1'b0;
      hold_clear    = 1'b1;
      if_id_n.inst  = NOP_INST;
      if_id_n.valid = 1'b0;
      state_n       = S_RUN;
    end else if (stall) begin
      // imem keeps re-reading pc_req while stalled; those repeats are marked invalid
      // so the first release edge restarts the stream at pc_req with no duplicate.
      resp_valid_n = 1'b0;
      if (resp_valid_q && !hold_valid) begin
        hold_capture = 1'b1;
        state_n      = S_HOLD;
      end
    end else begin
      if (cand_valid) begin
        if_id_n.inst  = cand_inst;
        if_id_n.pc    = cand_pc;
        if_id_n.valid = 1'b1;
      end else begin
        if_id_n.inst  = NOP_INST;
        if_id_n.valid = 1'b0;
      end
      pc_resp_n    = pc_req_q;
      resp_valid_n = 1'b1;
      pc_req_n     = pc_req_q + 32'd4;  // wraps modulo 2^32
      hold_clear   = 1'b1;
      state_n      = S_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_req_q     <= RESET_PC;
      pc_resp_q    <= 32'd0;
      resp_valid_q <= 1'b0;
      if_id_q      <= '{inst: NOP_INST, pc: 32'd0, valid: 1'b0};
    end else begin
      pc_req_q     <= pc_req_n;
      pc_resp_q    <= pc_resp_n;
      resp_valid_q <= resp_valid_n;
      if_id_q      <= if_id_n;
    end
  end

  // imem_addr comes straight from a register: no combinational path from stall/flush.
  assign imem_addr = pc_req_q;
  assign id_inst   = if_id_q.inst;
  assign id_pc     = if_id_q.pc;
  assign id_valid  = if_id_q.valid;

endmodule
